cube_move_engine: RTL
=====================

// Module: cube_move_engine
// PURPOSE
//  Parametrised cube-state engine for the Rubik's cube display path. Takes face-turn requests
//  from switch/button inputs, buffers them in a move FIFO and applies each to a 54-sticker state
//  register as CW or CCW quarter turns. Emits a one-cycle redraw strobe per completed move.
//  Sits between board I/O (SW/KEY) and the VGA face renderer.
// PARAMETERS
//  COLOR_W   3   bits per sticker colour code
//  QDEPTH    8   move FIFO depth, power of 2, >=2
//  CNT_W     16  width of completed-move counter
// PORTS
//  CLOCK_50     in   1              system clock
//  resetn       in   1              async active-low reset (board KEY[0])
//  move_code    in   4              [2:0] face 0=F 1=B 2=L 3=R 4=U 5=D; [3] dir 0=CW 1=CCW (SW[3:0])
//  move_req_n   in   1              async active-low request button (KEY[1])
//  hold         in   1              1 = do not pop new moves; queue still accepts
//  cube_state   out  54*COLOR_W     sticker (f,i) at [(f*9+i)*COLOR_W +: COLOR_W], i row-major
//  redraw       out  1              1-cycle pulse after each completed move
//  busy         out  1              FSM not IDLE or FIFO not empty
//  queue_full   out  1              FIFO count == QDEPTH
//  overflow     out  1              sticky: push dropped because FIFO full
//  bad_move     out  1              sticky: request with face code 6 or 7
//  move_count   out  CNT_W          completed moves, wraps all-ones -> 0
// BEHAVIOUR
//  - Reset (async): cube_state solved (every sticker of face f = colour f); FIFO empty; FSM IDLE;
//    redraw/overflow/bad_move=0; move_count=0. In-progress move discarded, queued moves flushed.
//  - move_req_n and move_code pass a 2-FF synchroniser; press = synced 1->0 edge. Exactly one
//    request per press regardless of hold time. Code sampled from synced copy in the edge cycle.
//  - Request push happens on the cycle after the edge. Face 6/7: not pushed, bad_move<=1.
//    FIFO full: not pushed, overflow<=1, even if a pop occurs in the same cycle.
//  - Push and pop in the same cycle on a non-full, non-empty FIFO: both take effect; count unchanged.
//  - FSM IDLE: if !hold && !empty -> pop; latch face, passes = dir ? 3 : 1; go TURN.
//    TURN: each cycle cube_state <= turn(cube_state, face); passes--. Leave for DONE when passes==1.
//    DONE: redraw=1 for this cycle only, move_count++; go IDLE. DONE->IDLE pops the next move
//    one cycle later, so back-to-back moves yield redraw pulses >=3 cycles apart.
//  - Latency from pop edge: CW redraw high 2 cycles later; CCW redraw high 4 cycles later.
//    cube_state is stable whenever redraw=1 and while IDLE.
//  - hold raised mid-move: current move completes; only the next pop is blocked.
//  - cube_state never shows a partial CCW to the renderer: renderer latches only on redraw.
// STRUCTURE
//  - cube_pkg: NUM_FACES=6, STICKERS=9, face index constants, move_code field positions,
//    12-entry adjacent-edge tables per face, solved-state constant function.
//  - Sub-module cube_face_turn: combinational CW quarter turn of selected face.
//    Rotates that face's 9 stickers and cycles its 12 neighbouring edge stickers.
//    Instanced once; CCW obtained by 3 passes.
//  - Top level: synchroniser and edge detector, FIFO (ptrs with extra wrap bit), FSM, counter, flags.
// TESTING
//  1 reset -> all faces uniform colours 0..5, redraw=0, move_count=0, busy=0, flags 0
//  2 code 4'b0000 press -> one redraw pulse; F uniform 0; U stickers 6,7,8 = 2 (L colour);
//    move_count=1
//  3 then code 4'b1000 press -> state back to solved, move_count=2;
//    CCW redraw 2 cycles later than CW relative to pop
//  4 four presses of 4'b0011 (R CW) -> state solved, 4 redraw pulses, move_count=4
//  5 hold=1, 9 presses -> queue_full=1, overflow=1, no redraw;
//    hold=0 -> exactly 8 redraw pulses, busy falls after last
//  6 code 4'b0110 press -> bad_move=1, no redraw, state unchanged; resetn low during CCW TURN
//    -> solved state, FIFO empty, busy=0 immediately (no clock needed)

Source files
------------

// File: rtl/cube_pkg.sv
// Shared constants for the cube move engine: face numbering, move-code fields,
// sticker permutation tables for a clockwise quarter turn, and the solved colouring.
package cube_pkg;

  localparam int NUM_FACES    = 6;
  localparam int STICKERS     = 9;
  localparam int NUM_STICKERS = NUM_FACES * STICKERS;
  localparam int EDGE_LEN     = 12;

  typedef enum logic [2:0] {
    FACE_F = 3'd0,
    FACE_B = 3'd1,
    FACE_L = 3'd2,
    FACE_R = 3'd3,
    FACE_U = 3'd4,
    FACE_D = 3'd5
  } face_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  localparam int CODE_FACE_LSB = 0;
  localparam int CODE_FACE_W   = 3;
  localparam int CODE_DIR_BIT  = 3;

  // Source index inside a face for each destination sticker under a CW turn.
  localparam int ROT_SRC [STICKERS] = '{6, 3, 0, 7, 4, 1, 8, 5, 2};

  // Global sticker indices ringing each face, ordered so that a CW turn moves
  // entry k to entry k+3 (mod 12).
  localparam int EDGE_RING [NUM_FACES][EDGE_LEN] = '{
    '{42, 43, 44, 27, 30, 33, 47, 46, 45, 26, 23, 20},  // F
    '{38, 37, 36, 18, 21, 24, 51, 52, 53, 35, 32, 29},  // B
    '{36, 39, 42,  0,  3,  6, 45, 48, 51, 17, 14, 11},  // L
    '{44, 41, 38,  9, 12, 15, 53, 50, 47,  8,  5,  2},  // R
    '{11, 10,  9, 29, 28, 27,  2,  1,  0, 20, 19, 18},  // U
    '{ 6,  7,  8, 33, 34, 35, 15, 16, 17, 24, 25, 26}   // D
  };

  function automatic int unsigned solved_color(input int unsigned sticker);
    return sticker / STICKERS;
  endfunction

endpackage

// File: rtl/cube_move_engine_if.sv
// Board-side request inputs and renderer-side cube outputs of the move engine.
interface cube_move_engine_if
  import cube_pkg::*;
#(
  parameter int COLOR_W = 3,
  parameter int CNT_W   = 16
);
  logic [3:0]                      move_code;
  logic                            move_req_n;
  logic                            hold;
  logic [NUM_STICKERS*COLOR_W-1:0] cube_state;
  logic                            redraw;
  logic                            busy;
  logic                            queue_full;
  logic                            overflow;
  logic                            bad_move;
  logic [CNT_W-1:0]                move_count;

  modport master (
    output move_code, move_req_n, hold,
    input  cube_state, redraw, busy, queue_full, overflow, bad_move, move_count
  );

  modport slave (
    input  move_code, move_req_n, hold,
    output cube_state, redraw, busy, queue_full, overflow, bad_move, move_count
  );
endinterface

// File: rtl/cube_face_turn.sv
// Combinational clockwise quarter turn of one face: rotates its 9 stickers and
// cycles the 12 edge stickers of the neighbouring faces.
module cube_face_turn
  import cube_pkg::*;
#(
  parameter int COLOR_W = 3
) (
  input  face_e                           face,
  input  logic [NUM_STICKERS*COLOR_W-1:0] cur,
  output logic [NUM_STICKERS*COLOR_W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    for (int f = 0; f < NUM_FACES; f++) begin
      if (int'(face) == f) begin
        for (int i = 0; i < STICKERS; i++)
          nxt[(f*STICKERS+i)*COLOR_W +: COLOR_W] = cur[(f*STICKERS+ROT_SRC[i])*COLOR_W +: COLOR_W];
        for (int k = 0; k < EDGE_LEN; k++)
          nxt[EDGE_RING[f][(k+3)%EDGE_LEN]*COLOR_W +: COLOR_W] = cur[EDGE_RING[f][k]*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/cube_move_engine.sv
// Cube-state engine: synchronises button presses, queues moves in a FIFO and
// applies each as 1 (CW) or 3 (CCW) clockwise passes, pulsing redraw per move.
module cube_move_engine
  import cube_pkg::*;
#(
  parameter int COLOR_W = 3,
  parameter int QDEPTH  = 8,
  parameter int CNT_W   = 16
) (
  input logic               CLOCK_50,
  input logic               resetn,
  cube_move_engine_if.slave bus
);

  localparam int STATE_W = NUM_STICKERS * COLOR_W;
  localparam int AW      = $clog2(QDEPTH);

  function automatic logic [STATE_W-1:0] solved_state();
    logic [STATE_W-1:0] s;
    for (int n = 0; n < NUM_STICKERS; n++)
      s[n*COLOR_W +: COLOR_W] = COLOR_W'(solved_color(n));
    return s;
  endfunction

  localparam logic [STATE_W-1:0] SOLVED = solved_state();

  logic               req_p0, req_p1, req_p2, vld_p2;
  logic [3:0]         code_p0, code_p1, code_p2;
  logic               press;
  logic [3:0]         mem [QDEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               empty, full, bad_code, push;
  logic               bad_q, ovf_q;
  fsm_e               state_q, state_d;
  logic               pop, turn_en, done;
  face_e              face_q;
  logic [1:0]         passes_q;
  logic [STATE_W-1:0] cube_q, turned;
  logic [CNT_W-1:0]   count_q;

  // Stage p0/p1: two-flop synchroniser; p2: press edge and captured code
  assign press = req_p2 & ~req_p1;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      req_p0 <= 1'b1;
      req_p1 <= 1'b1;
      req_p2 <= 1'b1;
      vld_p2 <= 1'b0;
    end else begin
      req_p0 <= bus.move_req_n;
      req_p1 <= req_p0;
      req_p2 <= req_p1;
      vld_p2 <= press;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    code_p0 <= bus.move_code;
    code_p1 <= code_p0;
    if (press) code_p2 <= code_p1;
  end

  // Move FIFO: extra pointer bit separates full from empty
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bad_code = (code_p2[CODE_FACE_LSB +: CODE_FACE_W] > FACE_D);
  assign push     = vld_p2 && !bad_code && !full;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bad_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (vld_p2 && bad_code)          bad_q <= 1'b1;
      if (vld_p2 && !bad_code && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr[AW-1:0]] <= code_p2;
  end

  // Move sequencer
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    turn_en = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.hold && !empty) begin
          pop     = 1'b1;
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        turn_en = 1'b1;
        if (passes_q == 2'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (pop) begin
      face_q   <= face_e'(mem[rd_ptr[AW-1:0]][CODE_FACE_LSB +: CODE_FACE_W]);
      passes_q <= mem[rd_ptr[AW-1:0]][CODE_DIR_BIT] ? 2'd3 : 2'd1;
    end else if (turn_en) begin
      passes_q <= passes_q - 1'b1;
    end
  end

  cube_face_turn #(.COLOR_W(COLOR_W)) u_turn (
    .face (face_q),
    .cur  (cube_q),
    .nxt  (turned)
  );

  // Sticker state and completed-move counter
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cube_q  <= SOLVED;
      count_q <= '0;
    end else begin
      if (turn_en) cube_q  <= turned;
      if (done)    count_q <= count_q + 1'b1;
    end
  end

  assign bus.cube_state = cube_q;
  assign bus.redraw     = done;
  assign bus.busy       = (state_q != ST_IDLE) || !empty;
  assign bus.queue_full = full;
  assign bus.overflow   = ovf_q;
  assign bus.bad_move   = bad_q;
  assign bus.move_count = count_q;

endmodule
